// File: rtl/iguana_pkg.sv
// Shared types and constants for the iguana HyperBus boot-time configuration path.
package iguana_pkg;

    typedef struct packed {
        logic [47:0] addr;
        logic [31:0] data;
    } hyper_cfg_entry_t;

    // Default register-interface bundles seen by the HyperBus reg slave
    typedef struct packed {
        logic [47:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } hyper_reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } hyper_reg_rsp_t;

    typedef enum logic [1:0] {
        CfgWait,
        CfgWrite,
        CfgDone
    } hyper_cfg_state_e;

    localparam int unsigned HypCfgWaitCycles = 300 * 200;
    localparam int unsigned HypCfgNumEntries = 4;

    localparam hyper_cfg_entry_t [HypCfgNumEntries-1:0] HyperCfgDefault = {
        hyper_cfg_entry_t'{addr: 48'h0000_0000_000c, data: 32'h0000_0001},
        hyper_cfg_entry_t'{addr: 48'h0000_0000_0008, data: 32'h0000_0002},
        hyper_cfg_entry_t'{addr: 48'h0000_0000_0004, data: 32'h0000_0006},
        hyper_cfg_entry_t'{addr: 48'h0000_0000_0000, data: 32'h0000_0003}
    };

endpackage

// File: rtl/iguana_hyper_cfg_seq.sv
// Boot-time HyperBus register sequencer: waits for PHY startup, writes a fixed
// table to the controller, then becomes a transparent register pass-through.
module iguana_hyper_cfg_seq
    import iguana_pkg::*;
#(
    parameter type         reg_req_t  = hyper_reg_req_t,
    parameter type         reg_rsp_t  = hyper_reg_rsp_t,
    parameter int unsigned NumEntries = HypCfgNumEntries,
    parameter hyper_cfg_entry_t [NumEntries-1:0] CfgTable = HyperCfgDefault,
    parameter int unsigned WaitCycles = HypCfgWaitCycles,
    parameter int unsigned AckTimeout = 1024
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     skip_i,
    input  reg_req_t slv_req_i,
    output reg_rsp_t slv_rsp_o,
    output reg_req_t mst_req_o,
    input  reg_rsp_t mst_rsp_i,
    output logic     done_o,
    output logic     error_o
);

    localparam int unsigned IdxW     = (NumEntries > 1) ? $clog2(NumEntries) : 1;
    localparam int unsigned WaitW    = (WaitCycles > 1) ? $clog2(WaitCycles) : 1;
    localparam int unsigned TmoW     = (AckTimeout > 1) ? $clog2(AckTimeout) : 1;
    localparam int unsigned WaitLast = (WaitCycles > 0) ? WaitCycles - 1 : 0;
    localparam int unsigned TmoLast  = (AckTimeout > 0) ? AckTimeout - 1 : 0;
    localparam logic        TmoOn    = (AckTimeout != 0);

    localparam logic [IdxW-1:0]  IdxLast  = IdxW'(NumEntries - 1);
    localparam logic [WaitW-1:0] WaitEnd  = WaitW'(WaitLast);
    localparam logic [TmoW-1:0]  TmoEnd   = TmoW'(TmoLast);

    // A zero wait means the first write is issued in the first cycle out of reset
    localparam hyper_cfg_state_e StartState = (WaitCycles == 0) ? CfgWrite : CfgWait;

    hyper_cfg_state_e state, state_next;
    logic [IdxW-1:0]  idx, idx_next;
    logic [WaitW-1:0] wait_cnt, wait_cnt_next;
    logic [TmoW-1:0]  tmo_cnt, tmo_cnt_next;
    logic             err, err_next;
    hyper_cfg_entry_t entry;
    logic             timeout;

    assign entry   = CfgTable[idx];
    assign timeout = TmoOn && (tmo_cnt == TmoEnd);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state    <= StartState;
            idx      <= '0;
            wait_cnt <= '0;
            tmo_cnt  <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_next;
            idx      <= idx_next;
            wait_cnt <= wait_cnt_next;
            tmo_cnt  <= tmo_cnt_next;
            err      <= err_next;
        end
    end

    always_comb begin
        state_next    = state;
        idx_next      = idx;
        wait_cnt_next = wait_cnt;
        tmo_cnt_next  = tmo_cnt;
        err_next      = err;
        mst_req_o     = '0;
        slv_rsp_o     = '0;
        done_o        = 1'b0;

        unique case (state)
            CfgWait: begin
                if (wait_cnt != WaitEnd) begin
                    wait_cnt_next = wait_cnt + 1'b1;
                end
                if (skip_i) begin
                    state_next = CfgDone;
                end else if (wait_cnt == WaitEnd) begin
                    state_next = CfgWrite;
                end
            end

            CfgWrite: begin
                mst_req_o.addr  = entry.addr;
                mst_req_o.wdata = entry.data;
                mst_req_o.write = 1'b1;
                mst_req_o.wstrb = '1;
                mst_req_o.valid = 1'b1;
                if (mst_rsp_i.ready) begin
                    tmo_cnt_next = '0;
                    if (mst_rsp_i.error) begin
                        err_next   = 1'b1;
                        state_next = CfgDone;
                    end else if (idx == IdxLast) begin
                        state_next = CfgDone;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end else if (timeout) begin
                    err_next   = 1'b1;
                    state_next = CfgDone;
                end else if (tmo_cnt != TmoEnd) begin
                    tmo_cnt_next = tmo_cnt + 1'b1;
                end
            end

            CfgDone: begin
                mst_req_o = slv_req_i;
                slv_rsp_o = mst_rsp_i;
                done_o    = 1'b1;
            end

            default: begin
                state_next = StartState;
            end
        endcase

        // Reset withdraws an in-flight write in the very cycle it is sampled
        if (!rst_ni) begin
            mst_req_o = '0;
            slv_rsp_o = '0;
            done_o    = 1'b0;
        end
    end

    assign error_o = err & rst_ni;

endmodule

// File: tb/tb_iguana_hyper_cfg_seq.sv
// Randomized directed bench for iguana_hyper_cfg_seq against a timeline model.
module tb_iguana_hyper_cfg_seq;
    import iguana_pkg::*;

    localparam int W    = 10;
    localparam int N    = 3;
    localparam int TMO  = 8;
    localparam int MAXC = 128;

    localparam hyper_cfg_entry_t E0 =
        hyper_cfg_entry_t'{addr: 48'h1234_0000_0010, data: 32'hdead_beef};
    localparam hyper_cfg_entry_t E1 =
        hyper_cfg_entry_t'{addr: 48'h1234_0000_0024, data: 32'hcafe_f00d};
    localparam hyper_cfg_entry_t E2 =
        hyper_cfg_entry_t'{addr: 48'h1234_0000_0038, data: 32'h0bad_1dea};
    localparam hyper_cfg_entry_t [N-1:0] TB_TABLE = {E2, E1, E0};

    logic           clk = 1'b0;
    logic           rst_ni = 1'b0;
    logic           skip = 1'b0;
    hyper_reg_req_t slv_req = '0;
    hyper_reg_rsp_t slv_rsp;
    hyper_reg_req_t mst_req;
    hyper_reg_rsp_t mst_rsp = '0;
    logic           done;
    logic           error;

    int total = 0;
    int bad   = 0;

    // scenario controls
    int dly [N];
    int err_k;
    int skip_at;
    int soc_at;
    int abort_at;

    // model timeline
    int   exp_idx [MAXC];
    logic acc     [MAXC];
    logic accerr  [MAXC];
    int   done_at;
    logic exp_err;

    hyper_reg_req_t soc_req;

    iguana_hyper_cfg_seq #(
        .NumEntries (N),
        .CfgTable   (TB_TABLE),
        .WaitCycles (W),
        .AckTimeout (TMO)
    ) u_dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .skip_i    (skip),
        .slv_req_i (slv_req),
        .slv_rsp_o (slv_rsp),
        .mst_req_o (mst_req),
        .mst_rsp_i (mst_rsp),
        .done_o    (done),
        .error_o   (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected write timeline derived from per-entry slave delays
    task automatic build();
        int c;
        for (int i = 0; i < MAXC; i++) begin
            exp_idx[i] = -1;
            acc[i]     = 1'b0;
            accerr[i]  = 1'b0;
        end
        exp_err = 1'b0;
        if (skip_at >= 0) begin
            done_at = skip_at + 1;
            return;
        end
        c = W;
        for (int k = 0; k < N; k++) begin
            if (dly[k] >= TMO) begin
                for (int j = 0; j < TMO; j++) exp_idx[c + j] = k;
                done_at = c + TMO;
                exp_err = 1'b1;
                return;
            end
            for (int j = 0; j <= dly[k]; j++) exp_idx[c + j] = k;
            acc[c + dly[k]] = 1'b1;
            if (k == err_k) begin
                accerr[c + dly[k]] = 1'b1;
                done_at = c + dly[k] + 1;
                exp_err = 1'b1;
                return;
            end
            c += dly[k] + 1;
        end
        done_at = c;
    endtask

    task automatic run_seq();
        int ncyc;
        int k;
        build();
        ncyc = done_at + 3;
        soc_req       = '0;
        soc_req.addr  = 48'({$urandom(), $urandom()});
        soc_req.wdata = $urandom();
        soc_req.valid = 1'b1;
        rst_ni = 1'b0;
        @(posedge clk);
        #2;
        rst_ni = 1'b1;
        for (int t = 0; t < ncyc; t++) begin
            if (t > 0) begin
                @(posedge clk);
                #2;
            end
            skip = (t == skip_at);
            if (soc_at >= 0 && t >= soc_at) begin
                slv_req = soc_req;
            end else begin
                slv_req.addr  = 48'({$urandom(), $urandom()});
                slv_req.wdata = $urandom();
                slv_req.wstrb = 4'($urandom());
                slv_req.write = 1'($urandom());
                slv_req.valid = 1'b0;
            end
            mst_rsp.rdata = $urandom();
            if (t == done_at) begin
                mst_rsp.ready = 1'b1;
                mst_rsp.error = 1'b0;
            end else if (t > done_at || exp_idx[t] < 0) begin
                mst_rsp.ready = 1'($urandom());
                mst_rsp.error = 1'($urandom());
            end else begin
                mst_rsp.ready = acc[t];
                mst_rsp.error = accerr[t];
            end
            if (t == abort_at) rst_ni = 1'b0;
            #1;
            if (t == abort_at) begin
                chk("rst_valid", mst_req.valid, 1'b0);
                chk("rst_done", done, 1'b0);
                chk("rst_error", error, 1'b0);
                chk("rst_rsp", slv_rsp, '0);
                return;
            end else if (t >= done_at) begin
                chk("pt_req", mst_req, slv_req);
                chk("pt_rsp", slv_rsp, mst_rsp);
                chk("done_hi", done, 1'b1);
                chk("error_fin", error, exp_err);
            end else begin
                if (exp_idx[t] >= 0) begin
                    k = exp_idx[t];
                    chk("wr_valid", mst_req.valid, 1'b1);
                    chk("wr_addr", mst_req.addr, TB_TABLE[k].addr);
                    chk("wr_data", mst_req.wdata, TB_TABLE[k].data);
                    chk("wr_write", mst_req.write, 1'b1);
                    chk("wr_strb", mst_req.wstrb, 4'hf);
                end else begin
                    chk("idle_req", mst_req, '0);
                end
                chk("stall_rsp", slv_rsp, '0);
                chk("done_lo", done, 1'b0);
                chk("error_lo", error, 1'b0);
            end
        end
        skip = 1'b0;
    endtask

    task automatic plan(input int d0, input int d1, input int d2,
                        input int ek, input int sk, input int sa,
                        input int ab);
        dly[0]   = d0;
        dly[1]   = d1;
        dly[2]   = d2;
        err_k    = ek;
        skip_at  = sk;
        soc_at   = sa;
        abort_at = ab;
    endtask

    initial begin
        @(posedge clk);
        #3;
        chk("reset_done", done, 1'b0);
        chk("reset_error", error, 1'b0);
        chk("reset_mst", mst_req, '0);
        chk("reset_slv", slv_rsp, '0);

        // writes at 10,11,12; done at 13
        plan(0, 0, 0, -1, -1, -1, -1);
        run_seq();
        // entry 1 stalled 5 cycles
        plan(0, 5, 0, -1, -1, -1, -1);
        run_seq();
        // error response on entry 0
        plan(int'($urandom_range(0, 3)), 0, 0, 0, -1, -1, -1);
        run_seq();
        // slave never ready on entry 0
        plan(99, 0, 0, -1, -1, -1, -1);
        run_seq();
        // SoC read at cycle 2 held until forwarded
        plan(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
             int'($urandom_range(0, 4)), -1, -1, 2, -1);
        run_seq();
        // skip at cycle 0
        plan(0, 0, 0, -1, 0, 2, -1);
        run_seq();
        // reset during entry 1 stall, then full restart
        plan(0, 6, 0, -1, -1, -1, 14);
        run_seq();
        plan(0, 0, 0, -1, -1, 5, -1);
        run_seq();

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) begin
                dly[i] = ($urandom_range(0, 5) == 0) ? 9 : int'($urandom_range(0, 4));
            end
            err_k    = int'($urandom_range(0, 5));
            skip_at  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : -1;
            soc_at   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 12)) : -1;
            abort_at = -1;
            run_seq();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
